// File: rtl/target_spawner_pkg.sv
// Shared definitions for the target spawner: FSM state encoding and point values.
package target_spawner_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GAP    = 2'd1,
        SPAWN  = 2'd2,
        ACTIVE = 2'd3
    } state_e;

    localparam int unsigned PTS_NORMAL = 1;
    localparam int unsigned PTS_BONUS  = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, +1 or +2 per enabled cycle, synchronous active-low clear.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         inc2,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W:0]   sum;

    always_comb begin
        sum   = {1'b0, cnt_q} + (inc2 ? (W+1)'(2) : (W+1)'(1));
        cnt_d = cnt_q;
        if (inc) begin
            // Carry out means the add overflowed; clamp at all-ones.
            cnt_d = sum[W] ? '1 : sum[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/target_spawner.sv
// Turns LFSR words into timed game targets and keeps hit/miss tallies.
// Define TARGET_NO_REPEAT_EN to forbid two consecutive targets sharing an index.
module target_spawner
    import target_spawner_pkg::*;
#(
    parameter int unsigned NUM_TARGETS = 5,
    parameter int unsigned LIFE_CYCLES = 50,
    parameter int unsigned GAP_CYCLES  = 10,
    parameter int unsigned SCORE_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [4:0]             prn,
    input  logic                   ys,
    input  logic                   hit_valid,
    input  logic [4:0]             hit_idx,
    output logic                   target_vld,
    output logic [4:0]             target_idx,
    output logic [NUM_TARGETS-1:0] target_onehot,
    output logic                   bonus,
    output logic                   hit_pulse,
    output logic                   miss_pulse,
    output logic [SCORE_W-1:0]     score,
    output logic [SCORE_W-1:0]     miss_cnt
);

    localparam int unsigned CntMax = (LIFE_CYCLES > GAP_CYCLES) ? LIFE_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [CntW-1:0] GapLoad  = CntW'(GAP_CYCLES - 1);
    localparam logic [CntW-1:0] LifeLoad = CntW'(LIFE_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   vld_q, vld_d;
    logic [4:0]             idx_q, idx_d;
    logic                   bonus_q, bonus_d;
    logic [NUM_TARGETS-1:0] onehot_q, onehot_d;
    logic                   hit_q, hit_d;
    logic                   miss_q, miss_d;
    logic [4:0]             spawn_idx;
`ifdef TARGET_NO_REPEAT_EN
    logic [4:0]             last_idx_q, last_idx_d;
`endif

    always_comb begin
        spawn_idx = 5'(32'(prn) % NUM_TARGETS);
`ifdef TARGET_NO_REPEAT_EN
        if (spawn_idx == last_idx_q) begin
            spawn_idx = ((32'(spawn_idx) + 1) == NUM_TARGETS) ? 5'd0 : spawn_idx + 5'd1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        idx_d   = idx_q;
        bonus_d = bonus_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
`ifdef TARGET_NO_REPEAT_EN
        last_idx_d = last_idx_q;
`endif
        if (!en) begin
            state_d = IDLE;
            vld_d   = 1'b0;
            bonus_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = GAP;
                    cnt_d   = GapLoad;
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        state_d = SPAWN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                SPAWN: begin
                    idx_d   = spawn_idx;
                    bonus_d = ys;
                    vld_d   = 1'b1;
                    cnt_d   = LifeLoad;
                    state_d = ACTIVE;
`ifdef TARGET_NO_REPEAT_EN
                    last_idx_d = spawn_idx;
`endif
                end
                ACTIVE: begin
                    // A matching hit takes priority over a same-cycle timeout.
                    if (hit_valid && (hit_idx == idx_q)) begin
                        hit_d   = 1'b1;
                        vld_d   = 1'b0;
                        bonus_d = 1'b0;
                        state_d = GAP;
                        cnt_d   = GapLoad;
                    end else if (cnt_q == '0) begin
                        miss_d  = 1'b1;
                        vld_d   = 1'b0;
                        bonus_d = 1'b0;
                        state_d = GAP;
                        cnt_d   = GapLoad;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        onehot_d = vld_d ? (NUM_TARGETS'(1) << idx_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            vld_q    <= 1'b0;
            idx_q    <= '0;
            bonus_q  <= 1'b0;
            onehot_q <= '0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vld_q    <= vld_d;
            idx_q    <= idx_d;
            bonus_q  <= bonus_d;
            onehot_q <= onehot_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
        end
    end

`ifdef TARGET_NO_REPEAT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_idx_q <= '0;
        end else begin
            last_idx_q <= last_idx_d;
        end
    end
`endif

    sat_counter #(
        .W (SCORE_W)
    ) u_score (
        .clk  (clk),
        .rst  (rst),
        .inc  (hit_d),
        .inc2 (bonus_q),
        .q    (score)
    );

    sat_counter #(
        .W (SCORE_W)
    ) u_miss (
        .clk  (clk),
        .rst  (rst),
        .inc  (miss_d),
        .inc2 (1'b0),
        .q    (miss_cnt)
    );

    assign target_vld    = vld_q;
    assign target_idx    = idx_q;
    assign target_onehot = onehot_q;
    assign bonus         = bonus_q;
    assign hit_pulse     = hit_q;
    assign miss_pulse    = miss_q;

endmodule

// File: tb/tb_target_spawner.sv
// Directed self-checking bench for target_spawner (NUM_TARGETS=5, LIFE=4, GAP=2, SCORE_W=8).
module tb_target_spawner;

    localparam int unsigned NT = 5;
    localparam int unsigned LC = 4;
    localparam int unsigned GC = 2;
    localparam int unsigned SW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [4:0]    prn;
    logic          ys;
    logic          hit_valid;
    logic [4:0]    hit_idx;
    logic          target_vld;
    logic [4:0]    target_idx;
    logic [NT-1:0] target_onehot;
    logic          bonus;
    logic          hit_pulse;
    logic          miss_pulse;
    logic [SW-1:0] score;
    logic [SW-1:0] miss_cnt;

    int n_checks  = 0;
    int n_pass    = 0;
    int exp_score = 0;
    int exp_miss  = 0;
    int rep_idx;
    bit alt = 1'b0;

    target_spawner #(
        .NUM_TARGETS (NT),
        .LIFE_CYCLES (LC),
        .GAP_CYCLES  (GC),
        .SCORE_W     (SW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .prn           (prn),
        .ys            (ys),
        .hit_valid     (hit_valid),
        .hit_idx       (hit_idx),
        .target_vld    (target_vld),
        .target_idx    (target_idx),
        .target_onehot (target_onehot),
        .bonus         (bonus),
        .hit_pulse     (hit_pulse),
        .miss_pulse    (miss_pulse),
        .score         (score),
        .miss_cnt      (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat_add(input int v, input int pts);
        return (v + pts > 255) ? 255 : v + pts;
    endfunction

    // Starts right after a target ended (GAP just loaded): GAP x2, SPAWN, then ACTIVE.
    task automatic play(input logic [4:0] p, input logic y, input bit do_hit, input int exp_i);
        prn = p;
        ys  = y;
        repeat (3) step();
        check_eq("spawn_vld", target_vld, 1);
        check_eq("spawn_idx", target_idx, exp_i);
        check_eq("spawn_onehot", target_onehot, 32'(1) << exp_i);
        check_eq("spawn_bonus", bonus, y);
        if (do_hit) begin
            hit_valid = 1'b1;
            hit_idx   = 5'(exp_i);
            step();
            hit_valid = 1'b0;
            exp_score = sat_add(exp_score, y ? 2 : 1);
            check_eq("hit_pulse", hit_pulse, 1);
            check_eq("hit_vld_drop", target_vld, 0);
            check_eq("hit_score", score, exp_score);
        end else begin
            repeat (4) step();
            exp_miss++;
            check_eq("miss_pulse", miss_pulse, 1);
            check_eq("miss_cnt", miss_cnt, exp_miss);
            check_eq("miss_vld_drop", target_vld, 0);
        end
    endtask

    initial begin
        rst       = 1'b0;
        en        = 1'b0;
        prn       = 5'd0;
        ys        = 1'b0;
        hit_valid = 1'b0;
        hit_idx   = 5'd0;
        repeat (3) step();

        check_eq("rst_vld", target_vld, 0);
        check_eq("rst_idx", target_idx, 0);
        check_eq("rst_onehot", target_onehot, 0);
        check_eq("rst_bonus", bonus, 0);
        check_eq("rst_pulses", {hit_pulse, miss_pulse}, 0);
        check_eq("rst_score", score, 0);
        check_eq("rst_miss", miss_cnt, 0);

        // Normal spawn that times out.
        rst = 1'b1;
        en  = 1'b1;
        prn = 5'd13;
        ys  = 1'b0;
        repeat (3) step();
        check_eq("gap_no_vld", target_vld, 0);
        step();
        check_eq("t1_vld", target_vld, 1);
        check_eq("t1_idx", target_idx, 3);
        check_eq("t1_onehot", target_onehot, 5'b01000);
        check_eq("t1_bonus", bonus, 0);
        repeat (3) step();
        check_eq("t1_vld_4th", target_vld, 1);
        step();
        exp_miss = 1;
        check_eq("t1_vld_off", target_vld, 0);
        check_eq("t1_miss_pulse", miss_pulse, 1);
        check_eq("t1_miss_cnt", miss_cnt, exp_miss);

        // Bonus hit on 2nd active cycle; also a press during GAP must be ignored.
        prn       = 5'd7;
        ys        = 1'b1;
        hit_valid = 1'b1;
        hit_idx   = 5'd3;
        step();
        hit_valid = 1'b0;
        check_eq("gap_press_pulse", hit_pulse, 0);
        check_eq("gap_press_score", score, 0);
        check_eq("miss_pulse_once", miss_pulse, 0);
        repeat (2) step();
        check_eq("t2_vld", target_vld, 1);
        check_eq("t2_idx", target_idx, 2);
        check_eq("t2_bonus", bonus, 1);
        step();
        hit_valid = 1'b1;
        hit_idx   = 5'd2;
        step();
        hit_valid = 1'b0;
        exp_score = 2;
        check_eq("t2_hit_pulse", hit_pulse, 1);
        check_eq("t2_score", score, exp_score);
        check_eq("t2_vld_off", target_vld, 0);

        // Wrong index press, then matching hit on the timeout cycle.
        prn = 5'd14;
        ys  = 1'b0;
        step();
        check_eq("hit_pulse_once", hit_pulse, 0);
        repeat (2) step();
        check_eq("t3_idx", target_idx, 4);
        hit_valid = 1'b1;
        hit_idx   = 5'd1;
        step();
        hit_valid = 1'b0;
        check_eq("t3_wrong_pulse", hit_pulse, 0);
        check_eq("t3_wrong_vld", target_vld, 1);
        check_eq("t3_wrong_score", score, exp_score);
        repeat (2) step();
        hit_valid = 1'b1;
        hit_idx   = 5'd4;
        step();
        hit_valid = 1'b0;
        exp_score = 3;
        check_eq("t3_hit_pulse", hit_pulse, 1);
        check_eq("t3_no_miss_pulse", miss_pulse, 0);
        check_eq("t3_score", score, exp_score);
        check_eq("t3_miss_cnt", miss_cnt, exp_miss);

        // Repeat avoidance: idx 0, then two spawns of prn=9 (idx 4).
        play(5'd0, 1'b0, 1'b1, 0);
        play(5'd9, 1'b0, 1'b1, 4);
`ifdef TARGET_NO_REPEAT_EN
        rep_idx = 0;
`else
        rep_idx = 4;
`endif
        play(5'd9, 1'b0, 1'b1, rep_idx);

        // One timeout via the helper, then climb the score towards saturation.
        play(5'd2, 1'b0, 1'b0, 2);
        while (exp_score < 250) begin
            play(alt ? 5'd0 : 5'd1, 1'b1, 1'b1, alt ? 0 : 1);
            alt = ~alt;
        end
        while (exp_score < 251) begin
            play(alt ? 5'd0 : 5'd1, 1'b0, 1'b1, alt ? 0 : 1);
            alt = ~alt;
        end
        play(alt ? 5'd0 : 5'd1, 1'b0, 1'b1, alt ? 0 : 1);
        alt = ~alt;
        play(alt ? 5'd0 : 5'd1, 1'b1, 1'b1, alt ? 0 : 1);
        alt = ~alt;
        check_eq("preload_254", score, 254);
        play(alt ? 5'd0 : 5'd1, 1'b1, 1'b1, alt ? 0 : 1);
        alt = ~alt;
        check_eq("sat_255", score, 255);
        play(alt ? 5'd0 : 5'd1, 1'b0, 1'b1, alt ? 0 : 1);
        alt = ~alt;
        check_eq("sat_hold", score, 255);

        // Reset during ACTIVE.
        prn = 5'd13;
        ys  = 1'b1;
        repeat (3) step();
        check_eq("pre_rst_vld", target_vld, 1);
        rst = 1'b0;
        step();
        rst       = 1'b1;
        exp_score = 0;
        exp_miss  = 0;
        check_eq("mid_rst_vld", target_vld, 0);
        check_eq("mid_rst_idx", target_idx, 0);
        check_eq("mid_rst_onehot", target_onehot, 0);
        check_eq("mid_rst_bonus", bonus, 0);
        check_eq("mid_rst_score", score, 0);
        check_eq("mid_rst_miss", miss_cnt, 0);

        // Restart from IDLE takes one extra cycle.
        ys = 1'b0;
        repeat (3) step();
        check_eq("restart_gap", target_vld, 0);
        step();
        check_eq("restart_vld", target_vld, 1);
        check_eq("restart_idx", target_idx, 3);
        hit_valid = 1'b1;
        hit_idx   = 5'd3;
        step();
        hit_valid = 1'b0;
        exp_score = 1;
        check_eq("restart_score", score, exp_score);

        // en=0 during ACTIVE, with a matching press on the same cycle.
        prn = 5'd7;
        repeat (3) step();
        check_eq("pre_en_vld", target_vld, 1);
        en        = 1'b0;
        hit_valid = 1'b1;
        hit_idx   = 5'd2;
        step();
        hit_valid = 1'b0;
        check_eq("en0_vld", target_vld, 0);
        check_eq("en0_onehot", target_onehot, 0);
        check_eq("en0_bonus", bonus, 0);
        check_eq("en0_hit_pulse", hit_pulse, 0);
        check_eq("en0_score_held", score, exp_score);
        repeat (2) step();
        prn = 5'd11;
        en  = 1'b1;
        repeat (3) step();
        check_eq("en1_from_idle", target_vld, 0);
        step();
        check_eq("en1_vld", target_vld, 1);
        check_eq("en1_idx", target_idx, 1);
        check_eq("en1_score_held", score, exp_score);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/target_spawner.md
Name: target_spawner

Overview:
- Consumes the 5-bit pseudo-random word `prn` and the `ys` flag from the LFSR stage directly upstream.
- Turns them into timed "targets" for the game: which one of NUM_TARGETS lamps is lit, how long it stays lit, and whether the player hit it.
- Keeps the hit and miss counts and drives the lamp one-hot downstream.

Parameters:
- NUM_TARGETS, 5, number of selectable targets; legal range 2..32.
- LIFE_CYCLES, 50, clocks a target stays active before it counts as missed; minimum 1.
- GAP_CYCLES, 10, idle clocks between targets; minimum 1.
- SCORE_W, 8, width of the score and miss counters.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- en  in  1  game running; 0 forces IDLE.
- prn  in  5  random word from the LFSR.
- ys  in  1  bonus flag from the LFSR.
- hit_valid  in  1  player strobe, one cycle.
- hit_idx  in  5  target index the player pressed.
- target_vld  out  1  a target is active.
- target_idx  out  5  index of the active target.
- target_onehot  out  NUM_TARGETS  lamp drive; all zero when target_vld=0.
- bonus  out  1  the active target is worth 2 points.
- hit_pulse  out  1  one-cycle pulse on a scored hit.
- miss_pulse  out  1  one-cycle pulse on a timeout.
- score  out  SCORE_W  accumulated points.
- miss_cnt  out  SCORE_W  accumulated misses.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State = IDLE.
  - All outputs = 0, including score, miss_cnt and target_idx.
  - Internal counters = 0; last_idx = 0.
- States: IDLE, GAP, SPAWN, ACTIVE.
- IDLE: when en=1, go to GAP and load the counter with GAP_CYCLES-1.
- GAP: decrement the counter each clock; when it reaches 0, go to SPAWN.
- SPAWN (exactly one cycle):
  - Sample prn and ys.
  - idx = prn mod NUM_TARGETS; computed combinationally, result 0..NUM_TARGETS-1.
  - Register target_idx=idx, bonus=ys, last_idx=idx.
  - Go to ACTIVE with the life counter = LIFE_CYCLES-1.
  - target_vld rises on the clock after the SPAWN cycle (1-cycle latency from sample).
- ACTIVE, evaluated each clock:
  - hit_valid=1 and hit_idx==target_idx: score += bonus ? 2 : 1, saturating at all-ones; hit_pulse=1 for one cycle; target_vld=0; go to GAP.
  - hit_valid=1 with a wrong index: ignored, no penalty.
  - Life counter==0 with no matching hit: miss_cnt += 1, saturating; miss_pulse=1; target_vld=0; go to GAP.
  - A matching hit on the same cycle as the timeout: the hit wins; no miss is counted.
- hit_valid outside ACTIVE: ignored.
- en=0 in any state:
  - Next state is IDLE; target_vld, bonus and the pulses go to 0.
  - score and miss_cnt are held.
  - Any pending hit on that cycle is ignored.
- prn is sampled only in SPAWN; prn changing at other times has no effect.
- target_onehot = (1 << target_idx) when target_vld=1, else 0.
- target_onehot, target_vld, bonus and the pulses are registered, not combinational.

Optional Feature:
- Macro: TARGET_NO_REPEAT_EN.
- Defined: if the computed idx == last_idx in SPAWN, use (idx+1) wrapping to 0 at NUM_TARGETS. Two consecutive targets never share an index; latency is unchanged.
- Undefined: idx is used as is; repeats are allowed.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, GAP=2'd1, SPAWN=2'd2, ACTIVE=2'd3;
  - point values: PTS_NORMAL=1, PTS_BONUS=2.
- One sub-module: sat_counter (parameter W; increment by 1 or 2; saturates at all-ones; synchronous active-low clear). It is instantiated twice, for score and miss_cnt.

Test Plan (NUM_TARGETS=5, LIFE_CYCLES=4, GAP_CYCLES=2, SCORE_W=8):
- Normal spawn:
  - Stimulus: en=1, prn=5'd13, ys=0 at SPAWN.
  - Response: target_idx=3, target_onehot=5'b01000, target_vld high for exactly 4 cycles, then miss_pulse once and miss_cnt=1.
- Bonus hit:
  - Stimulus: prn=5'd7, ys=1; hit_valid with hit_idx=2 on the 2nd ACTIVE cycle.
  - Response: hit_pulse once, score=2, target_vld=0 the next cycle.
- Wrong index, then simultaneous events:
  - Stimulus: hit_idx=1 while target_idx=4, then hit_idx=4 on the last life cycle.
  - Response: first press ignored; score+1; miss_cnt unchanged.
- Saturation:
  - Stimulus: preload score to 8'd254 via 1 normal and 1 bonus hit.
  - Response: score=255 and stays 255.
- Reset and en mid-game:
  - Stimulus: rst=0 during ACTIVE.
  - Response: next clock all outputs 0.
  - Stimulus: en=0 during ACTIVE.
  - Response: IDLE, target_vld=0, score held.
- Repeat avoidance, with TARGET_NO_REPEAT_EN defined:
  - Stimulus: two consecutive SPAWNs with prn=5'd9 (idx 4).
  - Response: second target_idx=0.
  - Without the macro: second target_idx=4.
